dac_mix_scheduler: RTL and testbench
====================================

Name: dac_mix_scheduler

Overview:
- Time-multiplexed audio mixer and sample scheduler that feeds the input word of the sigma-delta DAC.
- Generates the audio sample tick and snapshots NCH unsigned source channels (beeper, tape, PSG A/B/C, ...).
- Scales each channel by a per-channel volume, using one shared multiplier sequenced over NCH cycles.
- Accumulates, shifts and saturates the sum, then loads the result into the DAC input register with a one-cycle valid strobe.

Parameters:
- NCH, 4, number of source channels (2..8).
- DW, 8, width of each channel sample (unsigned).
- VW, 4, width of each volume (unsigned; 0 = silent, all-ones = full).
- OUTW, 8, DAC input width (equals DAC MSBI+1).
- SHIFT, 4, right shift applied to the accumulated sum before saturation.
- TICK_DIV, 64, CLK cycles per output sample; must be >= NCH+3.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- ENABLE  in  1  1 = tick divider runs; 0 = divider held at 0, and any sample in progress completes.
- CH_IN  in  NCH*DW  channel samples, channel k at bits [k*DW +: DW].
- VOL_WE  in  1  volume register write strobe.
- VOL_ADDR  in  clog2(NCH)  channel index for the write.
- VOL_DATA  in  VW  volume value for the write.
- MUTE  in  1  forces the loaded DAC word to 0.
- STAT_CLR  in  1  clears the sticky CLIP and OVERRUN flags.
- DAC_DATA  out  OUTW  registered DAC input word.
- DAC_VALID  out  1  one-cycle pulse on each DAC_DATA load.
- BUSY  out  1  FSM is not in IDLE.
- CLIP  out  1  sticky flag: saturation occurred.
- OVERRUN  out  1  sticky flag: a tick was dropped while BUSY.

Behaviour:
- Reset values:
  - DAC_DATA=0, DAC_VALID=0, BUSY=0, CLIP=0, OVERRUN=0.
  - Divider=0, FSM=IDLE, accumulator=0, channel index=0.
  - All volumes = all-ones.
- Reset asserted mid-sample aborts the sample immediately; no partial load occurs.
- Divider:
  - Counts 0..TICK_DIV-1 while ENABLE=1.
  - tick is high in the cycle where count==TICK_DIV-1; the count then wraps to 0.
  - ENABLE=0 forces count=0 and tick=0.
- FSM states: IDLE, MAC, SAT, LOAD.
- Cycle T (tick=1 in IDLE):
  - At the closing edge, snapshot CH_IN into the sample register.
  - Clear the accumulator, set channel index=0, go to MAC.
- MAC (edges T+1..T+NCH):
  - acc <= acc + snap[ch]*vol[ch]; ch <= ch+1.
  - After ch=NCH-1, go to SAT.
  - Accumulator width = DW+VW+clog2(NCH); it never wraps.
- SAT (edge T+NCH+1):
  - s = acc >> SHIFT.
  - If s > 2^OUTW-1: result = 2^OUTW-1 and CLIP <= 1. Otherwise result = s[OUTW-1:0].
  - If MUTE=1 at this edge: result=0, and CLIP is not set for this sample.
- LOAD (edge T+NCH+2):
  - DAC_DATA <= result; DAC_VALID=1 for exactly this one cycle; go to IDLE.
  - Latency from the tick cycle to DAC_DATA change = NCH+2 edges.
- BUSY=1 in MAC, SAT and LOAD.
- Tick while not IDLE (only possible if TICK_DIV is misconfigured): the tick is dropped and OVERRUN <= 1.
- Volume writes:
  - Take effect at the next edge.
  - A write to channel k in the same cycle MAC reads vol[k] uses the old value.
  - VOL_ADDR >= NCH is ignored.
- CH_IN changes after the snapshot do not affect the current sample.
- STAT_CLR clears CLIP and OVERRUN. If clear and set occur on the same edge, set wins.
- DAC_DATA holds its value between loads, including while ENABLE=0.

Test Plan:
- Reset, ENABLE=1, NCH=4, all CH_IN=0x10, volumes default 0xF:
  - sum = 4*0x10*15 = 960; >>4 = 60.
  - DAC_DATA=0x3C, first DAC_VALID at cycle 63+6 after reset release; thereafter one DAC_VALID every 64 cycles.
- All CH_IN=0xFF, volumes 0xF:
  - 15300>>4 = 956 saturates, so DAC_DATA=0xFF and CLIP=1.
  - STAT_CLR pulse then clears CLIP=0.
- Volumes {0,0,0,8}, CH_IN ch3=0x80, others 0xFF:
  - 0x80*8 = 1024; >>4 = 64, so DAC_DATA=0x40 and CLIP=0.
- Change CH_IN one cycle after the tick; write VOL[2]=0 during MAC:
  - The current sample uses the snapshot.
  - The volume change applies per the MAC timing rule; the next sample reflects both changes.
- MUTE=1 with non-zero inputs: DAC_DATA=0, DAC_VALID still pulses, CLIP stays 0.
- Assert RESET during MAC: outputs return to reset values, no DAC_VALID is emitted, and normal operation resumes after release. Separately, set ENABLE=0 mid-sample: that sample still loads, then no further DAC_VALID appears.

Source files
------------

// File: rtl/dac_mix_scheduler.sv
// dac_mix_scheduler: tick-paced shared-multiplier mixer loading a saturated sum into the DAC input word
module dac_mix_scheduler #(
  parameter int NCH      = 4,
  parameter int DW       = 8,
  parameter int VW       = 4,
  parameter int OUTW     = 8,
  parameter int SHIFT    = 4,
  parameter int TICK_DIV = 64
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     ENABLE,
  input  logic [NCH*DW-1:0]        CH_IN,
  input  logic                     VOL_WE,
  input  logic [$clog2(NCH)-1:0]   VOL_ADDR,
  input  logic [VW-1:0]            VOL_DATA,
  input  logic                     MUTE,
  input  logic                     STAT_CLR,
  output logic [OUTW-1:0]          DAC_DATA,
  output logic                     DAC_VALID,
  output logic                     BUSY,
  output logic                     CLIP,
  output logic                     OVERRUN
);
  localparam int CW = $clog2(NCH);
  localparam int AW = DW + VW + CW;
  localparam int TW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE, MAC, SAT, LOAD} state_t;
  state_t state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   snap_q [NCH];
  logic [DW-1:0]   snap_d [NCH];
  logic [VW-1:0]   vol_q [NCH];
  logic [VW-1:0]   vol_d [NCH];
  logic [AW-1:0]   acc_q, acc_d, sum_s;
  logic [CW-1:0]   ch_q, ch_d;
  logic [OUTW-1:0] res_q, res_d, dac_q, dac_d;
  logic            valid_q, valid_d, clip_q, clip_d, ovr_q, ovr_d, tick, sat_hit;

  always_comb begin
    tick    = ENABLE && cnt_q == TW'(TICK_DIV - 1);
    cnt_d   = (ENABLE && !tick) ? cnt_q + 1'b1 : '0;
    state_d = state_q;
    acc_d   = acc_q;
    ch_d    = ch_q;
    snap_d  = snap_q;
    vol_d   = vol_q;
    res_d   = res_q;
    dac_d   = dac_q;
    sum_s   = acc_q >> SHIFT;
    sat_hit = 1'b0;
    if (VOL_WE && int'(VOL_ADDR) < NCH) vol_d[VOL_ADDR] = VOL_DATA;
    case (state_q)
      IDLE: if (tick) begin
        for (int i = 0; i < NCH; i++) snap_d[i] = CH_IN[i*DW +: DW];
        acc_d   = '0;
        ch_d    = '0;
        state_d = MAC;
      end
      MAC: begin
        acc_d   = acc_q + snap_q[ch_q] * vol_q[ch_q];
        ch_d    = ch_q + 1'b1;
        state_d = ch_q == CW'(NCH - 1) ? SAT : MAC;
      end
      SAT: begin
        sat_hit = !MUTE && (sum_s >> OUTW) != '0;
        res_d   = MUTE ? '0 : sat_hit ? '1 : sum_s[OUTW-1:0];
        state_d = LOAD;
      end
      default: begin
        dac_d   = res_q;
        state_d = IDLE;
      end
    endcase
    valid_d = state_q == LOAD;
    // a set on the same edge as a clear must survive
    clip_d  = (clip_q && !STAT_CLR) || sat_hit;
    ovr_d   = (ovr_q && !STAT_CLR) || (tick && state_q != IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ch_q    <= '0;
      res_q   <= '0;
      dac_q   <= '0;
      valid_q <= 1'b0;
      clip_q  <= 1'b0;
      ovr_q   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        snap_q[i] <= '0;
        vol_q[i]  <= '1;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ch_q    <= ch_d;
      res_q   <= res_d;
      dac_q   <= dac_d;
      valid_q <= valid_d;
      clip_q  <= clip_d;
      ovr_q   <= ovr_d;
      snap_q  <= snap_d;
      vol_q   <= vol_d;
    end
  end

  assign DAC_DATA  = dac_q;
  assign DAC_VALID = valid_q;
  assign BUSY      = state_q != IDLE;
  assign CLIP      = clip_q;
  assign OVERRUN   = ovr_q;
endmodule

// File: tb/tb_dac_mix_scheduler.sv
// tb_dac_mix_scheduler: timeline model of the mixer checked every cycle, plus directed literal checks
module tb_dac_mix_scheduler;
  localparam int NCH = 4, DW = 8, VW = 4, OUTW = 8, SHIFT = 4, TICK_DIV = 64;
  logic CLK = 0, RESET, ENABLE, VOL_WE, MUTE, STAT_CLR;
  logic [NCH*DW-1:0] CH_IN;
  logic [1:0] VOL_ADDR;
  logic [VW-1:0] VOL_DATA;
  logic [OUTW-1:0] DAC_DATA;
  logic DAC_VALID, BUSY, CLIP, OVERRUN;
  int vecs = 0, errs = 0, edges = -1;

  dac_mix_scheduler #(.NCH(NCH), .DW(DW), .VW(VW), .OUTW(OUTW), .SHIFT(SHIFT), .TICK_DIV(TICK_DIV)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .CH_IN(CH_IN), .VOL_WE(VOL_WE), .VOL_ADDR(VOL_ADDR),
    .VOL_DATA(VOL_DATA), .MUTE(MUTE), .STAT_CLR(STAT_CLR), .DAC_DATA(DAC_DATA), .DAC_VALID(DAC_VALID),
    .BUSY(BUSY), .CLIP(CLIP), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK or posedge RESET) edges <= RESET ? -1 : edges + 1;

  task automatic chk(string name, int act, int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: sample is tracked by its age in edges since the tick's closing edge
  initial begin
    int m_cnt, m_age, m_acc, m_dac, m_res, s;
    bit m_active, m_valid, m_clip, m_ovr, tick, was_active, set_clip;
    int m_vol [NCH];
    int m_snap [NCH];
    forever begin
      @(negedge CLK);
      if (RESET) begin
        m_cnt = 0; m_age = 0; m_acc = 0; m_dac = 0; m_res = 0;
        m_active = 0; m_valid = 0; m_clip = 0; m_ovr = 0;
        for (int i = 0; i < NCH; i++) m_vol[i] = 15;
      end
      chk("cyc DAC_DATA", DAC_DATA, m_dac);
      chk("cyc DAC_VALID", DAC_VALID, m_valid);
      chk("cyc BUSY", BUSY, m_active);
      chk("cyc CLIP", CLIP, m_clip);
      chk("cyc OVERRUN", OVERRUN, m_ovr);
      if (!RESET) begin
        tick = ENABLE && m_cnt == TICK_DIV - 1;
        was_active = m_active;
        m_valid = 0;
        set_clip = 0;
        if (m_active) begin
          m_age++;
          if (m_age >= 1 && m_age <= NCH) m_acc += m_snap[m_age-1] * m_vol[m_age-1];
          if (m_age == NCH + 1) begin
            s = m_acc >> SHIFT;
            if (MUTE) m_res = 0;
            else if (s > 2**OUTW - 1) begin m_res = 2**OUTW - 1; set_clip = 1; end
            else m_res = s;
          end
          if (m_age == NCH + 2) begin m_dac = m_res; m_valid = 1; m_active = 0; end
        end else if (tick) begin
          m_active = 1; m_age = 0; m_acc = 0;
          for (int i = 0; i < NCH; i++) m_snap[i] = int'(CH_IN[i*DW +: DW]);
        end
        if (VOL_WE && int'(VOL_ADDR) < NCH) m_vol[VOL_ADDR] = int'(VOL_DATA);
        m_clip = (m_clip && !STAT_CLR) || set_clip;
        m_ovr = (m_ovr && !STAT_CLR) || (tick && was_active);
        m_cnt = !ENABLE ? 0 : tick ? 0 : m_cnt + 1;
      end
    end
  end

  task automatic wait_valid(output int d, output int e);
    bit got = 0;
    d = -1; e = -1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge CLK);
      if (DAC_VALID) begin got = 1; d = int'(DAC_DATA); e = edges; end
    end
    chk("valid seen", got, 1);
  endtask

  task automatic wait_busy();
    bit got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge CLK);
      got = BUSY;
    end
    chk("busy seen", got, 1);
  endtask

  task automatic set_vol(input int a, input int v);
    @(posedge CLK); #1 VOL_WE = 1; VOL_ADDR = 2'(a); VOL_DATA = VW'(v);
    @(posedge CLK); #1 VOL_WE = 0;
  endtask

  initial begin
    int d, e, e2, n;
    RESET = 1; ENABLE = 1; CH_IN = {NCH{8'h10}}; VOL_WE = 0; VOL_ADDR = 0; VOL_DATA = 0;
    MUTE = 0; STAT_CLR = 0;
    repeat (3) @(negedge CLK);
    chk("reset DAC_DATA", DAC_DATA, 0);
    chk("reset BUSY", BUSY, 0);
    @(posedge CLK); #1 RESET = 0;
    // 4*0x10*15 = 960 >> 4 = 60; tick closes at edge 63, load 6 edges later
    wait_valid(d, e);
    chk("first data", d, 'h3C);
    chk("first edge", e, 69);
    wait_valid(d, e2);
    chk("period", e2 - e, 64);
    chk("second data", d, 'h3C);
    @(posedge CLK); #1 CH_IN = {NCH{8'hFF}};
    wait_valid(d, e);
    chk("sat data", d, 'hFF);
    chk("sat clip", CLIP, 1);
    @(posedge CLK); #1 STAT_CLR = 1;
    @(posedge CLK); #1 STAT_CLR = 0;
    @(negedge CLK) chk("clip cleared", CLIP, 0);
    // 0x80*8 = 1024 >> 4 = 64
    set_vol(0, 0); set_vol(1, 0); set_vol(2, 0); set_vol(3, 8);
    CH_IN = {8'h80, 8'hFF, 8'hFF, 8'hFF};
    wait_valid(d, e);
    chk("vol data", d, 'h40);
    chk("vol clip", CLIP, 0);
    set_vol(0, 15); set_vol(1, 15); set_vol(2, 15); set_vol(3, 15);
    CH_IN = {NCH{8'h10}};
    // CH_IN change right after the snapshot, vol[2]=0 written as MAC reads vol[2]
    wait_busy();
    #1 CH_IN = {NCH{8'h20}};
    @(posedge CLK); @(posedge CLK); #1 VOL_WE = 1; VOL_ADDR = 2; VOL_DATA = 0;
    @(posedge CLK); #1 VOL_WE = 0;
    wait_valid(d, e);
    chk("snapshot data", d, 'h3C);
    wait_valid(d, e);
    chk("next data", d, 'h5A);
    set_vol(2, 15);
    CH_IN = {NCH{8'hFF}}; MUTE = 1;
    wait_valid(d, e);
    chk("mute data", d, 0);
    chk("mute clip", CLIP, 0);
    @(posedge CLK); #1 MUTE = 0; CH_IN = {NCH{8'h10}};
    wait_valid(d, e);
    chk("unmute data", d, 'h3C);
    // abort mid-MAC; the aborted sample would have mixed with vol[0]=0
    set_vol(0, 0);
    wait_busy();
    @(posedge CLK); #1 RESET = 1;
    repeat (2) @(negedge CLK);
    chk("abort DAC_DATA", DAC_DATA, 0);
    chk("abort BUSY", BUSY, 0);
    chk("abort VALID", DAC_VALID, 0);
    @(posedge CLK); #1 RESET = 0;
    wait_valid(d, e);
    chk("resume edge", e, 69);
    chk("resume data", d, 'h3C);
    wait_busy();
    #1 ENABLE = 0;
    wait_valid(d, e);
    chk("disable data", d, 'h3C);
    n = 0;
    repeat (200) @(negedge CLK) n += DAC_VALID;
    chk("disabled pulses", n, 0);
    chk("disabled hold", DAC_DATA, 'h3C);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
